mac_array_sequencer: RTL and testbench

- Command-driven control FSM that sequences one MAC array.
- Loads a kernel of K weight rows from weight BRAM into the preload stage, then commits them to the MACs.
- Streams ifmap beats from the ifmap FIFO into the array and tracks in-flight results through a fixed-latency pipeline to psum_valid.
- Sits between the AXI-lite command/status registers and the MAC array datapath.

---
 rtl/mac_array_sequencer_if.sv | 22 ++
 rtl/mac_array_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_mac_array_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_sequencer_if.sv
// rtl/mac_array_sequencer_if.sv - command handshake bus between the register block and the MAC array sequencer
interface mac_array_sequencer_if #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int CNT_WIDTH          = 16
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [31:0]                   cmd_opcode;
  logic [4:0]                    cmd_kernel_size;
  logic [BRAM_ADDRESS_WIDTH-1:0] cmd_weight_base;
  logic [CNT_WIDTH-1:0]          cmd_beats;

  modport master (
    output cmd_valid, cmd_opcode, cmd_kernel_size, cmd_weight_base, cmd_beats,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_kernel_size, cmd_weight_base, cmd_beats,
    output cmd_ready
  );
endinterface

// File: rtl/mac_array_sequencer.sv
// rtl/mac_array_sequencer.sv - command FSM sequencing weight load and ifmap streaming for one MAC array (optional stall counter: MAC_ARRAY_SEQ_PERF_CNT_EN)
module mac_array_sequencer #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int KMAX               = 5,
  parameter int CNT_WIDTH          = 16,
  parameter int PIPE_LAT           = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mac_array_sequencer_if.slave          cmd,
  output logic [BRAM_ADDRESS_WIDTH-1:0] weight_addr,
  output logic                          weight_rd_en,
  output logic                          load_weight_preload,
  output logic                          load_mac_weight,
  output logic [4:0]                    kernel_size,
  input  logic                          ifmaps_fifo_empty,
  output logic                          ifmaps_rd_en,
  output logic                          load_ifmaps,
  input  logic                          psum_ready,
  output logic                          psum_valid,
  output logic                          done_pulse,
  output logic [31:0]                   status
);

  localparam logic [31:0] OP_LOAD_WEIGHT = 32'd86;
  localparam logic [31:0] OP_COMPUTE     = 32'd87;

  typedef enum logic [2:0] {IDLE, W_READ, W_LAST, W_COMMIT, C_RUN, C_DRAIN} state_t;

  state_t               state;
  logic [4:0]           lat_k;
  logic [4:0]           w_idx;
  logic [CNT_WIDTH-1:0] lat_beats;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 weights_loaded;
  logic                 compute_done;
  logic                 err_kernel;
  logic                 err_no_weight;
  logic                 err_opcode;
  logic                 fifo_starved;
  logic [PIPE_LAT-1:0]  valid_sr;
  logic [PIPE_LAT-1:0]  pipe_next;
  logic                 accept;
  logic                 issue;
  logic                 k_legal;
  logic                 busy;
  logic [15:0]          status_hi;

  assign cmd.cmd_ready = (state == IDLE);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign k_legal       = (cmd.cmd_kernel_size != 5'd0) && (cmd.cmd_kernel_size <= 5'(KMAX));
  assign busy          = (state != IDLE);

  // A beat is consumed only when data is present, downstream can take it, and beats remain.
  assign issue        = (state == C_RUN) & ~ifmaps_fifo_empty & psum_ready & (beat_cnt < lat_beats);
  assign ifmaps_rd_en = issue;
  assign load_ifmaps  = issue;

  // Contents of the in-flight tracker after the coming edge; drain ends when this is empty.
  assign pipe_next  = (valid_sr << 1) | PIPE_LAT'(issue);
  assign psum_valid = valid_sr[PIPE_LAT-1];

  // Fixed-latency tracker: each issued beat emerges as psum_valid PIPE_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= pipe_next;
    end
  end

  // Command FSM with registered strobes, latched command fields and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      weight_addr         <= '0;
      weight_rd_en        <= 1'b0;
      load_weight_preload <= 1'b0;
      load_mac_weight     <= 1'b0;
      kernel_size         <= 5'd0;
      done_pulse          <= 1'b0;
      lat_k               <= 5'd0;
      w_idx               <= 5'd0;
      lat_beats           <= '0;
      beat_cnt            <= '0;
      weights_loaded      <= 1'b0;
      compute_done        <= 1'b0;
      err_kernel          <= 1'b0;
      err_no_weight       <= 1'b0;
      err_opcode          <= 1'b0;
      fifo_starved        <= 1'b0;
    end else begin
      done_pulse          <= 1'b0;
      load_mac_weight     <= 1'b0;
      load_weight_preload <= weight_rd_en;
      if (issue) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
      if ((state == C_RUN) && ifmaps_fifo_empty) begin
        fifo_starved <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            compute_done  <= 1'b0;
            err_kernel    <= 1'b0;
            err_no_weight <= 1'b0;
            err_opcode    <= 1'b0;
            fifo_starved  <= 1'b0;
            lat_k         <= cmd.cmd_kernel_size;
            lat_beats     <= cmd.cmd_beats;
            if (cmd.cmd_opcode == OP_LOAD_WEIGHT) begin
              if (k_legal) begin
                state        <= W_READ;
                weight_rd_en <= 1'b1;
                weight_addr  <= cmd.cmd_weight_base;
                w_idx        <= 5'd0;
              end else begin
                err_kernel <= 1'b1;
                done_pulse <= 1'b1;
              end
            end else if (cmd.cmd_opcode == OP_COMPUTE) begin
              beat_cnt <= '0;
              if (!weights_loaded) begin
                err_no_weight <= 1'b1;
                done_pulse    <= 1'b1;
              end else if (cmd.cmd_beats == '0) begin
                state <= C_DRAIN;
              end else begin
                state <= C_RUN;
              end
            end else begin
              err_opcode <= 1'b1;
              done_pulse <= 1'b1;
            end
          end
        end
        W_READ: begin
          if (w_idx == (lat_k - 5'd1)) begin
            weight_rd_en <= 1'b0;
            state        <= W_LAST;
          end else begin
            weight_addr <= weight_addr + BRAM_ADDRESS_WIDTH'(1);
            w_idx       <= w_idx + 5'd1;
          end
        end
        W_LAST: begin
          state           <= W_COMMIT;
          load_mac_weight <= 1'b1;
          done_pulse      <= 1'b1;
          kernel_size     <= lat_k;
          weights_loaded  <= 1'b1;
        end
        W_COMMIT: begin
          state <= IDLE;
        end
        C_RUN: begin
          if (beat_cnt == lat_beats) begin
            state <= C_DRAIN;
          end
        end
        C_DRAIN: begin
          if (pipe_next == '0) begin
            state        <= IDLE;
            done_pulse   <= 1'b1;
            compute_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_ARRAY_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt;

  // Saturating count of run cycles that wanted a beat but could not issue one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (accept) begin
      stall_cnt <= 16'd0;
    end else if ((state == C_RUN) && (beat_cnt < lat_beats) && !issue && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign status_hi = stall_cnt;
`else
  assign status_hi = 16'(beat_cnt);
`endif

  assign status = {status_hi, 9'd0, fifo_starved, err_opcode, err_no_weight,
                   err_kernel, compute_done, weights_loaded, busy};

endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb/tb_mac_array_sequencer.sv - self-checking bench for mac_array_sequencer
module tb_mac_array_sequencer;
  localparam int AW   = 12;
  localparam int KMAX = 5;
  localparam int CW   = 16;
  localparam int PL   = 2;
  localparam int NC   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mac_array_sequencer_if #(.BRAM_ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) cmd_bus ();

  logic [AW-1:0] weight_addr;
  logic          weight_rd_en, load_weight_preload, load_mac_weight;
  logic [4:0]    kernel_size;
  logic          ifmaps_fifo_empty, ifmaps_rd_en, load_ifmaps;
  logic          psum_ready, psum_valid, done_pulse;
  logic [31:0]   status;

  mac_array_sequencer #(.BRAM_ADDRESS_WIDTH(AW), .KMAX(KMAX), .CNT_WIDTH(CW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_bus),
    .weight_addr(weight_addr), .weight_rd_en(weight_rd_en),
    .load_weight_preload(load_weight_preload), .load_mac_weight(load_mac_weight),
    .kernel_size(kernel_size), .ifmaps_fifo_empty(ifmaps_fifo_empty),
    .ifmaps_rd_en(ifmaps_rd_en), .load_ifmaps(load_ifmaps), .psum_ready(psum_ready),
    .psum_valid(psum_valid), .done_pulse(done_pulse), .status(status)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
    end
  endtask

  // Model state: architectural registers as the specification describes them.
  bit          m_wl, m_cd, m_ek, m_enw, m_eop, m_fs;
  logic [4:0]  m_ks;
  logic [15:0] m_hi;

  // Per-cycle expectations for the current command, index 0 = accept cycle.
  bit            e_rd[NC], e_pre[NC], e_mac[NC], e_ifrd[NC], e_psum[NC], e_done[NC];
  logic [AW-1:0] e_addr[NC];
  logic [4:0]    e_ks[NC];
  logic [31:0]   e_status[NC];
  bit            s_empty[NC], s_ready[NC];

  function automatic logic [31:0] pack(input bit busy);
    return {m_hi, 9'd0, m_fs, m_eop, m_enw, m_ek, m_cd, m_wl, busy};
  endfunction

  task automatic model_reset();
    m_wl = 0; m_cd = 0; m_ek = 0; m_enw = 0; m_eop = 0; m_fs = 0; m_ks = 5'd0; m_hi = 16'd0;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < NC; i++) begin
      e_rd[i] = 0; e_pre[i] = 0; e_mac[i] = 0; e_ifrd[i] = 0; e_psum[i] = 0; e_done[i] = 0;
      e_addr[i] = '0; e_ks[i] = m_ks; e_status[i] = 32'd0;
    end
    e_status[0] = pack(0);
  endtask

  task automatic sched_default();
    for (int i = 0; i < NC; i++) begin
      s_empty[i] = 0; s_ready[i] = 1;
    end
  endtask

  task automatic accept_clear();
    m_cd = 0; m_ek = 0; m_enw = 0; m_eop = 0; m_fs = 0;
`ifdef MAC_ARRAY_SEQ_PERF_CNT_EN
    m_hi = 16'd0;
`endif
  endtask

  // Rejected commands stay idle and pulse done one cycle after accept.
  task automatic finish_reject(output int n);
    e_done[1] = 1; e_status[1] = pack(0); e_status[2] = pack(0); n = 3;
  endtask

  task automatic model_load(input int base, input int k, output int n);
    clr_exp();
    accept_clear();
    if (k < 1 || k > KMAX) begin
      m_ek = 1;
      finish_reject(n);
    end else begin
      for (int c = 1; c <= k + 1; c++) e_status[c] = pack(1);
      for (int i = 0; i < k; i++) begin
        e_rd[1 + i] = 1; e_addr[1 + i] = AW'(base + i); e_pre[2 + i] = 1;
      end
      m_wl = 1; m_ks = 5'(k);
      e_mac[k + 2] = 1; e_done[k + 2] = 1; e_status[k + 2] = pack(1);
      e_ks[k + 2] = m_ks; e_ks[k + 3] = m_ks;
      e_status[k + 3] = pack(0);
      n = k + 4;
    end
  endtask

  task automatic model_badop(output int n);
    clr_exp();
    accept_clear();
    m_eop = 1;
    finish_reject(n);
  endtask

  task automatic model_compute(input int beats, output int n);
    int cnt, stalls, last, c, ds, d;
    bit at_end;
    clr_exp();
    accept_clear();
    cnt = 0; stalls = 0; last = -100; ds = 1;
`ifndef MAC_ARRAY_SEQ_PERF_CNT_EN
    m_hi = 16'd0;
`endif
    if (!m_wl) begin
      m_enw = 1;
      finish_reject(n);
    end else begin
      if (beats != 0) begin
        c = 1;
        while (c < NC - 8) begin
          e_status[c] = pack(1);
          at_end = (cnt == beats);
          if (!at_end && !s_empty[c] && s_ready[c]) begin
            e_ifrd[c] = 1; cnt++; last = c; e_psum[c + PL] = 1;
          end else if (!at_end) begin
            stalls++;
          end
          if (s_empty[c]) m_fs = 1;
`ifdef MAC_ARRAY_SEQ_PERF_CNT_EN
          m_hi = 16'(stalls);
`else
          m_hi = 16'(cnt);
`endif
          if (at_end) begin
            ds = c + 1;
            break;
          end
          c++;
        end
      end
      d = ds + 1;
      if (last + PL + 1 > d) d = last + PL + 1;
      for (int i = ds; i < d; i++) e_status[i] = pack(1);
      m_cd = 1;
      e_done[d] = 1; e_status[d] = pack(0);
      n = d + 1;
    end
  endtask

  // Compare process: every output against the model on each cycle of a command.
  bit               active = 0;
  int               cyc = 0;
  int               obs_done = -1;
  int               obs_issue = 0;
  logic [AW-1:0]    addr_q[$];

  always @(negedge clk) begin
    if (active) begin
      chk("weight_rd_en", cyc, 32'(weight_rd_en), 32'(e_rd[cyc]));
      if (e_rd[cyc]) begin
        chk("weight_addr", cyc, 32'(weight_addr), 32'(e_addr[cyc]));
      end
      if (weight_rd_en) addr_q.push_back(weight_addr);
      chk("load_weight_preload", cyc, 32'(load_weight_preload), 32'(e_pre[cyc]));
      chk("load_mac_weight", cyc, 32'(load_mac_weight), 32'(e_mac[cyc]));
      chk("ifmaps_rd_en", cyc, 32'(ifmaps_rd_en), 32'(e_ifrd[cyc]));
      chk("load_ifmaps", cyc, 32'(load_ifmaps), 32'(e_ifrd[cyc]));
      chk("psum_valid", cyc, 32'(psum_valid), 32'(e_psum[cyc]));
      chk("done_pulse", cyc, 32'(done_pulse), 32'(e_done[cyc]));
      chk("status", cyc, status, e_status[cyc]);
      chk("kernel_size", cyc, 32'(kernel_size), 32'(e_ks[cyc]));
      chk("cmd_ready", cyc, 32'(cmd_bus.cmd_ready), 32'(!e_status[cyc][0]));
      if (done_pulse && obs_done < 0) obs_done = cyc;
      if (ifmaps_rd_en) obs_issue++;
    end
  end

  task automatic run(input logic [31:0] op, input int k, input int base, input int beats, input int n);
    @(posedge clk); #1;
    cmd_bus.cmd_valid       = 1'b1;
    cmd_bus.cmd_opcode      = op;
    cmd_bus.cmd_kernel_size = 5'(k);
    cmd_bus.cmd_weight_base = AW'(base);
    cmd_bus.cmd_beats       = CW'(beats);
    obs_done = -1; obs_issue = 0; addr_q.delete();
    cyc = 0; ifmaps_fifo_empty = s_empty[0]; psum_ready = s_ready[0]; active = 1;
    for (int c = 1; c < n; c++) begin
      @(posedge clk); #1;
      cmd_bus.cmd_valid = 1'b0;
      cyc = c; ifmaps_fifo_empty = s_empty[c]; psum_ready = s_ready[c];
    end
    @(posedge clk); #1;
    active = 0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_strobes"}, 0,
        32'({weight_rd_en, load_weight_preload, load_mac_weight, ifmaps_rd_en, load_ifmaps, psum_valid, done_pulse}),
        32'd0);
    chk({tag, "_status"}, 0, status, 32'd0);
    chk({tag, "_weight_addr"}, 0, 32'(weight_addr), 32'd0);
    chk({tag, "_kernel_size"}, 0, 32'(kernel_size), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_opcode = 32'd0; cmd_bus.cmd_kernel_size = 5'd0;
    cmd_bus.cmd_weight_base = '0; cmd_bus.cmd_beats = '0;
    ifmaps_fifo_empty = 1'b0; psum_ready = 1'b1;
    sched_default();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // LOAD_WEIGHT K=3 at 0x0FE
    model_load(32'h0FE, 3, n);
    run(32'd86, 3, 32'h0FE, 0, n);
    chk("t1_done_cycle", 0, 32'(obs_done), 32'd5);
    chk("t1_status", 0, status, 32'h0000_0002);
    chk("t1_kernel_size", 0, 32'(kernel_size), 32'd3);
    chk("t1_addr_count", 0, 32'(addr_q.size()), 32'd3);
    if (addr_q.size() == 3) chk("t1_addr_last", 0, 32'(addr_q[2]), 32'h100);

    // LOAD_WEIGHT K=2 wrapping at the top of BRAM, then an illegal K
    model_load(32'hFFF, 2, n);
    run(32'd86, 2, 32'hFFF, 0, n);
    chk("t2_addr_count", 0, 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      chk("t2_addr0", 0, 32'(addr_q[0]), 32'hFFF);
      chk("t2_addr1", 0, 32'(addr_q[1]), 32'h000);
    end
    model_load(32'h0, 6, n);
    run(32'd86, 6, 32'h0, 0, n);
    chk("t2_err_kernel_status", 0, status, 32'h0000_000A);
    chk("t2_kernel_size_kept", 0, 32'(kernel_size), 32'd2);

    // COMPUTE beats=4, FIFO always full, downstream ready
    sched_default();
    model_compute(4, n);
    run(32'd87, 0, 0, 4, n);
    chk("t3_done_cycle", 0, 32'(obs_done), 32'd7);
    chk("t3_issues", 0, 32'(obs_issue), 32'd4);
`ifdef MAC_ARRAY_SEQ_PERF_CNT_EN
    chk("t3_status", 0, status, 32'h0000_0006);
`else
    chk("t3_status", 0, status, 32'h0004_0006);
`endif

    // COMPUTE beats=3 with starvation and a downstream throttle
    sched_default();
    s_empty[2] = 1; s_empty[3] = 1; s_ready[5] = 0;
    model_compute(3, n);
    run(32'd87, 0, 0, 3, n);
    chk("t4_issues", 0, 32'(obs_issue), 32'd3);
    chk("t4_done_cycle", 0, 32'(obs_done), 32'd9);
    chk("t4_status", 0, status, 32'h0003_0046);

    // COMPUTE beats=0 drains immediately
    sched_default();
    model_compute(0, n);
    run(32'd87, 0, 0, 0, n);
    chk("t5_done_cycle", 0, 32'(obs_done), 32'd2);
    chk("t5_status", 0, status, 32'h0000_0006);

    // Illegal opcode
    model_badop(n);
    run(32'd88, 0, 0, 0, n);
    chk("t6_done_cycle", 0, 32'(obs_done), 32'd1);
    chk("t6_status", 0, status, 32'h0000_0022);

    // Reset while results are in flight
    sched_default();
    ifmaps_fifo_empty = 1'b0; psum_ready = 1'b1;
    @(posedge clk); #1;
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_opcode = 32'd87; cmd_bus.cmd_beats = CW'(8);
    @(posedge clk); #1;
    cmd_bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t7_in_flight", 3, 32'(psum_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero("t7_async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    model_compute(5, n);
    run(32'd87, 0, 0, 5, n);
    chk("t7_no_weight_status", 0, status, 32'h0000_0010);
    chk("t7_no_weight_issues", 0, 32'(obs_issue), 32'd0);
    chk("t7_no_weight_done", 0, 32'(obs_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
